alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
Two-requester arbiter that shares one combinational ALU instance between two issue sources, for example the main execute path and a secondary address/branch helper. It grants at most one request per cycle using round-robin priority. It drives the shared ALU's op and operand inputs from the granted request, captures the ALU result at the clock edge, and returns it through a one-deep per-requester response buffer with valid/ready backpressure.

Parameters:
DW, 32, operand/result width
OPW, 10, one-hot ALU op width; bit order from MSB: add, sub, sll, slt, sltu, xor, srl, sra, or, and
CNTW, 16, width of saturating conflict counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 granted this cycle
req0_op  in  OPW  one-hot op (all-zero legal, yields result 0)
req0_src1  in  DW  operand 1
req0_src2  in  DW  operand 2
req1_valid / req1_ready / req1_op / req1_src1 / req1_src2  same as requester 0, for requester 1
alu_op  out  OPW  to shared ALU
alu_src1  out  DW  to shared ALU
alu_src2  out  DW  to shared ALU
alu_result  in  DW  from shared ALU (combinational)
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  DW  registered result
rsp1_valid / rsp1_ready / rsp1_result  same as response 0, for requester 1
conflict_cnt  out  CNTW  cycles in which both requesters were eligible

Behaviour:
- Reset (async, immediate):
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_result = rsp1_result = 0.
  - conflict_cnt = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
  - No grant while rst is high.
- Eligibility: eligN = reqN_valid & (~rspN_valid | rspN_ready). A full response slot that is draining this cycle counts as free.
- Grant, combinational within the cycle:
  - Only one requester eligible: it is granted.
  - Both eligible: grant the requester that is not last_grant.
  - Neither eligible: no grant.
  - reqN_ready = grantN. The handshake completes on reqN_valid & reqN_ready at the clock edge.
- last_grant updates to the granted index only on a cycle with a grant; otherwise it holds.
- ALU drive:
  - With a grant, alu_op/alu_src1/alu_src2 equal the granted request's fields.
  - With no grant, all three are 0, so the ALU output is 0.
  - The block adds no logic between alu_result and the capture register.
- Latency: one cycle. A request accepted at edge k gives rspN_valid = 1 with rspN_result = alu_result, sampled at edge k.
- Response slot N, per edge:
  - Capture: rspN_valid <= 1, rspN_result <= alu_result.
  - No capture, rspN_ready = 1: rspN_valid <= 0; rspN_result holds its value.
  - Capture and rspN_ready = 1 in the same cycle: rspN_valid stays 1 and the data is replaced by the new result. Back-to-back throughput is one result per cycle per requester.
  - No capture, rspN_ready = 0: hold.
- Requester obligations:
  - Payload stays stable while reqN_valid & ~reqN_ready.
  - reqN_valid is not withdrawn before the grant.
  - The block does not check these and does not check the one-hot encoding of op.
- conflict_cnt: increments on any cycle with elig0 & elig1 and saturates at all-ones. It counts independently of response backpressure on the losing side.
- Total throughput: at most one ALU op per cycle. Each requester sees at most one outstanding result.

Test Plan:
- Single request: req0 add (op=10'b1000000000), src1=5, src2=3, rsp0_ready=1 -> req0_ready=1 that cycle, alu_src1=5; next cycle rsp0_valid=1, rsp0_result=8; following cycle rsp0_valid=0.
- Contention: both valid every cycle for 4 cycles, both rsp_ready=1 -> grants go 0,1,0,1; conflict_cnt=4; each rsp_valid toggles with correct results; alu_op=0 on idle cycles after.
- Backpressure: rsp0 full with rsp0_ready=0, req0 and req1 valid -> req0_ready=0, req1 granted each cycle, conflict_cnt unchanged. Raise rsp0_ready -> req0 granted that same cycle.
- Drain plus capture: rsp0_valid=1, rsp0_ready=1, new req0 sub with src1=2, src2=5 -> rsp0_valid stays 1, rsp0_result=32'hFFFFFFFD. Follow with slt, src1=32'hFFFFFFFF, src2=1 -> result 1.
- Async reset: assert rst between edges while both rsp slots are full and requests are pending -> rsp_valid and conflict_cnt go to 0 immediately, req_ready=0. After release with both valid, requester 0 is granted first.
- Saturation: hold both eligible for 65540 cycles -> conflict_cnt=16'hFFFF and remains there; grants still alternate.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// Round-robin grant, single-cycle capture of the ALU result into a
// one-deep response slot per requester, and a saturating count of
// cycles in which both requesters competed for the ALU.
module alu_share_arb #(
  parameter int DW   = 32,
  parameter int OPW  = 10,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [DW-1:0]   req0_src1,
  input  logic [DW-1:0]   req0_src2,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [DW-1:0]   req1_src1,
  input  logic [DW-1:0]   req1_src2,

  output logic [OPW-1:0]  alu_op,
  output logic [DW-1:0]   alu_src1,
  output logic [DW-1:0]   alu_src2,
  input  logic [DW-1:0]   alu_result,

  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [DW-1:0]   rsp0_result,

  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [DW-1:0]   rsp1_result,

  output logic [CNTW-1:0] conflict_cnt
);

  // Index of the requester granted most recently; 1 after reset so
  // requester 0 wins the first tie.
  logic last_grant;

  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // A requester may issue when its response slot is empty or is being
  // drained this same cycle.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  // Round-robin arbitration: on a tie the requester that did not win
  // last time is granted. Nothing is granted while reset is asserted.
  always_comb begin
    grant0 = ~rst & elig0 & (~elig1 | last_grant);
    grant1 = ~rst & elig1 & (~elig0 | ~last_grant);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Steer the granted request onto the shared ALU; drive zeros when idle
  // so the ALU output is a quiet 0.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    alu_op   = '0;
    alu_src1 = '0;
    alu_src2 = '0;
    if (grant0) begin
      alu_op   = req0_op;
      alu_src1 = req0_src1;
      alu_src2 = req0_src2;
    end else if (grant1) begin
      alu_op   = req1_op;
      alu_src1 = req1_src1;
      alu_src2 = req1_src2;
    end
  end

  // Round-robin pointer: remember the winner of every granted cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0 | grant1) begin
      last_grant <= grant1;
    end
  end

  // Response slot 0: capture the ALU result on a grant, otherwise empty
  // the slot when the consumer takes it; data holds when not captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
    end else if (grant0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  // Response slot 1: same behaviour as slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
    end else if (grant1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

  // Count cycles where both requesters were eligible, saturating at
  // all-ones; the losing side's backpressure does not affect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (elig0 & elig1 & (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and random stimulus for alu_share_arb,
// compared against a transaction-level reference model of the arbiter
// and response slots. The bench also plays the role of the shared ALU.
module tb_alu_share_arb;

  localparam int DW      = 32;
  localparam int OPW     = 10;
  localparam int CNTW    = 16;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  localparam logic [OPW-1:0] OP_ADD  = 10'b1000000000;
  localparam logic [OPW-1:0] OP_SUB  = 10'b0100000000;
  localparam logic [OPW-1:0] OP_SLT  = 10'b0001000000;

  logic            clk;
  logic            rst;
  logic            r_valid [2];
  logic [OPW-1:0]  r_op    [2];
  logic [DW-1:0]   r_src1  [2];
  logic [DW-1:0]   r_src2  [2];
  logic            k_ready [2];

  logic            req0_ready;
  logic            req1_ready;
  logic [OPW-1:0]  alu_op;
  logic [DW-1:0]   alu_src1;
  logic [DW-1:0]   alu_src2;
  logic [DW-1:0]   alu_result;
  logic            rsp0_valid;
  logic            rsp1_valid;
  logic [DW-1:0]   rsp0_result;
  logic [DW-1:0]   rsp1_result;
  logic [CNTW-1:0] conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic          m_valid  [2];
  logic [DW-1:0] m_result [2];
  int            m_cnt;
  int            m_next;   // requester that wins the next tie

  alu_share_arb #(.DW(DW), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (r_valid[0]),
    .req0_ready   (req0_ready),
    .req0_op      (r_op[0]),
    .req0_src1    (r_src1[0]),
    .req0_src2    (r_src2[0]),
    .req1_valid   (r_valid[1]),
    .req1_ready   (req1_ready),
    .req1_op      (r_op[1]),
    .req1_src1    (r_src1[1]),
    .req1_src2    (r_src2[1]),
    .alu_op       (alu_op),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_result   (alu_result),
    .rsp0_valid   (rsp0_valid),
    .rsp0_ready   (k_ready[0]),
    .rsp0_result  (rsp0_result),
    .rsp1_valid   (rsp1_valid),
    .rsp1_ready   (k_ready[1]),
    .rsp1_result  (rsp1_result),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: one-hot op, MSB first add, sub, sll, slt, sltu,
  // xor, srl, sra, or, and; all-zero op yields 0.
  function automatic logic [DW-1:0] alu_ref(input logic [OPW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      10'b1000000000: r = a + b;
      10'b0100000000: r = a - b;
      10'b0010000000: r = a << b[4:0];
      10'b0001000000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10'b0000100000: r = (a < b) ? 32'd1 : 32'd0;
      10'b0000010000: r = a ^ b;
      10'b0000001000: r = a >> b[4:0];
      10'b0000000100: r = $unsigned($signed(a) >>> b[4:0]);
      10'b0000000010: r = a | b;
      10'b0000000001: r = a & b;
      default:        r = '0;
    endcase
    return r;
  endfunction

  always_comb alu_result = alu_ref(alu_op, alu_src1, alu_src2);

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_valid[n]  = 1'b0;
      m_result[n] = '0;
    end
    m_cnt  = 0;
    m_next = 0;
  endtask

  task automatic check_regs();
    check("rsp0_valid",  rsp0_valid,   m_valid[0]);
    check("rsp1_valid",  rsp1_valid,   m_valid[1]);
    check("rsp0_result", rsp0_result,  m_result[0]);
    check("rsp1_result", rsp1_result,  m_result[1]);
    check("conflict_cnt", conflict_cnt, m_cnt);
  endtask

  // One clock cycle: check the combinational grant and ALU drive, cross
  // the edge, advance the model, then check the registered outputs.
  // Returns the granted index, or -1 when nothing was granted.
  task automatic step(output int g);
    logic          el0, el1;
    logic [DW-1:0] cap;
    #2;
    el0 = r_valid[0] && (!m_valid[0] || k_ready[0]);
    el1 = r_valid[1] && (!m_valid[1] || k_ready[1]);
    if (el0 && el1)  g = m_next;
    else if (el0)    g = 0;
    else if (el1)    g = 1;
    else             g = -1;
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    if (g >= 0) begin
      check("alu_op",   alu_op,   r_op[g]);
      check("alu_src1", alu_src1, r_src1[g]);
      check("alu_src2", alu_src2, r_src2[g]);
      cap = alu_ref(r_op[g], r_src1[g], r_src2[g]);
    end else begin
      check("alu_op_idle",   alu_op,   0);
      check("alu_src1_idle", alu_src1, 0);
      check("alu_src2_idle", alu_src2, 0);
      cap = '0;
    end
    @(posedge clk);
    #1;
    if (el0 && el1 && m_cnt < CNT_MAX) m_cnt++;
    for (int n = 0; n < 2; n++) begin
      if (g == n) begin
        m_valid[n]  = 1'b1;
        m_result[n] = cap;
      end else if (k_ready[n]) begin
        m_valid[n]  = 1'b0;
      end
    end
    if (g >= 0) m_next = 1 - g;
    check_regs();
  endtask

  // Assert reset between edges, check the immediate effect, release it
  // away from the next edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_req0_ready",  req0_ready,   0);
    check("rst_req1_ready",  req1_ready,   0);
    check("rst_rsp0_valid",  rsp0_valid,   0);
    check("rst_rsp1_valid",  rsp1_valid,   0);
    check("rst_rsp0_result", rsp0_result,  0);
    check("rst_rsp1_result", rsp1_result,  0);
    check("rst_conflict",    conflict_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [OPW-1:0] rand_op();
    int idx;
    idx = $urandom_range(0, OPW);
    return (idx == OPW) ? '0 : (OPW'(1) << idx);
  endfunction

  task automatic new_payload(input int n);
    r_op[n]   = rand_op();
    r_src1[n] = $urandom();
    r_src2[n] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom();
  endtask

  int g;
  int prev_g;
  int grants [4];
  logic [CNTW-1:0] cnt_saved;

  initial begin
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      r_valid[n] = 1'b1;  // requests pending during reset must not be granted
      r_op[n]    = OP_ADD;
      r_src1[n]  = 32'd1;
      r_src2[n]  = 32'd2;
      k_ready[n] = 1'b1;
    end
    model_reset();
    #2;
    pulse_reset();

    // Single request: add 5 + 3.
    r_valid[1] = 1'b0;
    r_op[0] = OP_ADD; r_src1[0] = 32'd5; r_src2[0] = 32'd3;
    step(g);
    check("single_grant", g, 0);
    check("single_result", rsp0_result, 32'd8);
    check("single_valid", rsp0_valid, 1);
    r_valid[0] = 1'b0;
    step(g);
    check("single_drained", rsp0_valid, 0);

    // Contention: four tied cycles from a fresh reset go 0,1,0,1.
    pulse_reset();
    r_valid[0] = 1'b1; r_valid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      new_payload(0);
      new_payload(1);
      step(grants[i]);
    end
    check("cont_g0", grants[0], 0);
    check("cont_g1", grants[1], 1);
    check("cont_g2", grants[2], 0);
    check("cont_g3", grants[3], 1);
    check("cont_cnt", conflict_cnt, 4);
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    step(g);
    step(g);
    check("cont_idle_op", alu_op, 0);

    // Backpressure: fill slot 0 and stall its consumer.
    k_ready[0] = 1'b0;
    r_valid[0] = 1'b1; r_op[0] = OP_ADD; r_src1[0] = 32'd7; r_src2[0] = 32'd9;
    step(g);
    check("bp_fill", rsp0_result, 32'd16);
    r_valid[1] = 1'b1;
    cnt_saved = conflict_cnt;
    for (int i = 0; i < 3; i++) begin
      new_payload(1);
      step(g);
      check("bp_req1_wins", g, 1);
    end
    check("bp_cnt_held", conflict_cnt, cnt_saved);
    k_ready[0] = 1'b1;
    #2;
    check("bp_release_ready", req0_ready, 1);
    step(g);

    // Drain plus capture in the same cycle.
    r_valid[1] = 1'b0;
    r_op[0] = OP_SUB; r_src1[0] = 32'd2; r_src2[0] = 32'd5;
    step(g);
    check("dc_valid", rsp0_valid, 1);
    check("dc_sub", rsp0_result, 32'hFFFFFFFD);
    r_op[0] = OP_SLT; r_src1[0] = 32'hFFFFFFFF; r_src2[0] = 32'd1;
    step(g);
    check("dc_slt", rsp0_result, 32'd1);
    r_valid[0] = 1'b0;
    step(g);

    // Random traffic honouring the request-side protocol.
    g = -1;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!r_valid[n] || g == n) begin
          r_valid[n] = ($urandom_range(0, 9) < 7);
          new_payload(n);
        end
        k_ready[n] = ($urandom_range(0, 3) != 0);
      end
      step(g);
    end

    // Async reset with both slots full and requests pending.
    k_ready[0] = 1'b0; k_ready[1] = 1'b0;
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    step(g);
    k_ready[0] = 1'b1; k_ready[1] = 1'b1;
    step(g);
    k_ready[0] = 1'b0; k_ready[1] = 1'b0;
    r_valid[0] = 1'b1; r_valid[1] = 1'b1;
    new_payload(0);
    new_payload(1);
    step(g);
    step(g);
    check("ar_full0", rsp0_valid, 1);
    check("ar_full1", rsp1_valid, 1);
    #2;
    pulse_reset();
    k_ready[0] = 1'b1; k_ready[1] = 1'b1;
    step(g);
    check("ar_first_grant", g, 0);

    // Saturation: keep both eligible long enough to pin the counter.
    prev_g = g;
    for (int i = 0; i < 65540; i++) begin
      step(g);
      if (i % 4096 == 0) check("sat_alternate", g, 1 - prev_g);
      prev_g = g;
    end
    check("sat_cnt", conflict_cnt, 16'hFFFF);
    step(g);
    check("sat_hold", conflict_cnt, 16'hFFFF);
    check("sat_alt_final", g, 1 - prev_g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
